// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Streams a program image into the program memory write port.
//               A byte stream (valid/ready) carries a count byte N
//               (0 means 2**PC_WIDTH words), then N words sent high byte first.
//               Each pair of bytes is packed into one IRWidth-bit word and
//               written to ascending addresses starting at 0. The CPU is held
//               for the whole load, and a one-cycle done pulse marks the end.
// Option      : LOADER_CHECKSUM_EN - when defined, one extra byte after the
//               last word must equal the XOR of all data bytes. On a mismatch
//               err is raised, done is suppressed and cpu_hold stays high
//               until the next start or reset.
// Ports       : clk          clock, rising edge
//               res          synchronous reset, active-high
//               start        begin a load (sampled in IDLE only)
//               byte_in      stream data
//               byte_valid   byte_in valid
//               byte_ready   loader accepts a byte this cycle
//               mem_wr_en    program memory write strobe (1 cycle)
//               mem_wr_adr   write address
//               mem_wr_data  write data {hi,lo}
//               cpu_hold     keep CPU stalled during the load
//               busy         load in progress
//               done         1-cycle pulse, load finished OK
//               err          checksum failure, sticky until next start
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader #(
  parameter int PC_WIDTH  = 8,
  parameter int IRWidth   = 16,
  parameter int ByteWidth = 8
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 start,
  input  logic [ByteWidth-1:0] byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 mem_wr_en,
  output logic [PC_WIDTH-1:0]  mem_wr_adr,
  output logic [IRWidth-1:0]   mem_wr_data,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  // Word counter is one bit wider than the address so a count byte of 0
  // can represent a full-depth load of 2**PC_WIDTH words.
  localparam logic [PC_WIDTH:0] c_FULL_DEPTH = {1'b1, {PC_WIDTH{1'b0}}};
  localparam logic [PC_WIDTH:0] c_ONE_WORD   = {{PC_WIDTH{1'b0}}, 1'b1};

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5,
    S_CHK   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;
`endif

  state_t                r_state;
  logic [PC_WIDTH:0]     r_words_left;
  logic [PC_WIDTH-1:0]   r_adr;
  logic [ByteWidth-1:0]  r_hi;
  logic                  r_wr_en;
  logic [PC_WIDTH-1:0]   r_wr_adr;
  logic [IRWidth-1:0]    r_wr_data;
  logic                  r_cpu_hold;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_ready;
  logic                  w_accept;
  logic [PC_WIDTH-1:0]   w_count;

`ifdef LOADER_CHECKSUM_EN
  logic                  r_err;
  logic [ByteWidth-1:0]  r_chk;
`endif

  // Ready is a pure decode of the state so the producer sees it without
  // an extra register stage.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_COUNT, S_HI, S_LO: w_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:               w_ready = 1'b1;
`endif
      default:             w_ready = 1'b0;
    endcase
  end

  assign w_accept = byte_valid && w_ready;
  assign w_count  = byte_in[PC_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (res) begin
      r_state      <= S_IDLE;
      r_words_left <= '0;
      r_adr        <= '0;
      r_hi         <= '0;
      r_wr_en      <= 1'b0;
      r_wr_adr     <= '0;
      r_wr_data    <= '0;
      r_cpu_hold   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_err        <= 1'b0;
      r_chk        <= '0;
`endif
    end else begin
      // Strobe and done are single-cycle pulses by default.
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_COUNT;
            r_busy     <= 1'b1;
            r_cpu_hold <= 1'b1;
            r_adr      <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_err      <= 1'b0;
            r_chk      <= '0;
`endif
          end
        end

        S_COUNT: begin
          if (w_accept) begin
            r_words_left <= (w_count == '0) ? c_FULL_DEPTH : {1'b0, w_count};
            r_state      <= S_HI;
          end
        end

        S_HI: begin
          if (w_accept) begin
            r_hi    <= byte_in;
`ifdef LOADER_CHECKSUM_EN
            r_chk   <= r_chk ^ byte_in;
`endif
            r_state <= S_LO;
          end
        end

        S_LO: begin
          if (w_accept) begin
            // Address and data are captured here so the strobe in WRITE
            // sees stable values; they then hold until the next word.
            r_wr_data <= {r_hi, byte_in};
            r_wr_adr  <= r_adr;
            r_wr_en   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            r_chk     <= r_chk ^ byte_in;
`endif
            r_state   <= S_WRITE;
          end
        end

        S_WRITE: begin
          r_adr        <= r_adr + 1'b1;
          r_words_left <= r_words_left - 1'b1;
          if (r_words_left == c_ONE_WORD) begin
`ifdef LOADER_CHECKSUM_EN
            r_state    <= S_CHK;
`else
            r_state    <= S_FIN;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_cpu_hold <= 1'b0;
`endif
          end else begin
            r_state <= S_HI;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_accept) begin
            r_busy  <= 1'b0;
            r_state <= S_FIN;
            if (byte_in == r_chk) begin
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              // Leave the CPU held: the image in memory is not trustworthy.
              r_err <= 1'b1;
            end
          end
        end
`endif

        S_FIN: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign byte_ready  = w_ready;
  assign mem_wr_en   = r_wr_en;
  assign mem_wr_adr  = r_wr_adr;
  assign mem_wr_data = r_wr_data;
  assign cpu_hold    = r_cpu_hold;
  assign busy        = r_busy;
  assign done        = r_done;
`ifdef LOADER_CHECKSUM_EN
  assign err         = r_err;
`else
  assign err         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none

module tb_program_loader;

  logic        clk = 1'b0;
  logic        res;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_adr;
  logic [15:0] mem_wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  program_loader #(
    .PC_WIDTH (8),
    .IRWidth  (16),
    .ByteWidth(8)
  ) dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_adr (mem_wr_adr),
    .mem_wr_data(mem_wr_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write/done monitor, sampled on the falling edge.
  logic [7:0]  wa_q[$];
  logic [15:0] wd_q[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      wa_q.push_back(mem_wr_adr);
      wd_q.push_back(mem_wr_data);
    end
    if (done === 1'b1) done_cnt++;
  end

  // Load vectors: count byte, number of words, word data, gapped stream.
  typedef struct {
    logic [7:0]  cnt;
    int          nw;
    logic [15:0] w[3];
    bit          gaps;
  } vec_t;

  vec_t vt[4];

  task automatic set_vec(input int k, input logic [7:0] cnt, input int nw,
                         input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input bit gaps);
    vt[k].cnt  = cnt;
    vt[k].nw   = nw;
    vt[k].w[0] = w0;
    vt[k].w[1] = w1;
    vt[k].w[2] = w2;
    vt[k].gaps = gaps;
  endtask

  // Negative index selects the full-depth pattern {i, ~i}.
  function automatic logic [15:0] word_of(input int vidx, input int i);
    logic [7:0] a;
    a = i[7:0];
    if (vidx < 0) return {a, ~a};
    return vt[vidx].w[i];
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    int g;
    t = 0;
    g = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (g) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) begin
      n_vec++;
      n_err++;
      $display("FAIL byte_timeout: byte %0h not accepted, ready=%b expected 1", b, byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_load(input int vidx, input logic [7:0] cnt, input int nw, input bit gaps);
    logic [7:0]  x;
    logic [15:0] w;
    int          n;
    x = 8'h00;
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    pulse_start();
    check("busy_after_start", busy, 1);
    check("hold_after_start", cpu_hold, 1);
    send_byte(cnt, gaps);
    for (int i = 0; i < nw; i++) begin
      w = word_of(vidx, i);
      send_byte(w[15:8], gaps);
      send_byte(w[7:0], gaps);
      x = x ^ w[15:8] ^ w[7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x, gaps);
`endif
    repeat (4) @(negedge clk);
    check("write_count", wa_q.size(), nw);
    n = (wa_q.size() < nw) ? wa_q.size() : nw;
    for (int i = 0; i < n; i++) begin
      check("write_adr", wa_q[i], i & 8'hFF);
      check("write_data", wd_q[i], word_of(vidx, i));
    end
    check("done_pulses", done_cnt, 1);
    check("busy_end", busy, 0);
    check("hold_end", cpu_hold, 0);
    check("err_end", err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    set_vec(0, 8'h02, 2, 16'h1234, 16'hABCD, 16'h0000, 1'b0);
    set_vec(1, 8'h02, 2, 16'h1234, 16'hABCD, 16'h0000, 1'b1);
    set_vec(2, 8'h01, 1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
    set_vec(3, 8'h03, 3, 16'h0001, 16'h8000, 16'h5A5A, 1'b0);

    // Reset with start and a valid byte present: reset must win.
    res        = 1'b1;
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h02;
    repeat (2) @(negedge clk);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_adr", mem_wr_adr, 0);
    check("rst_data", mem_wr_data, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ready", byte_ready, 0);

    // Valid bytes while idle are ignored.
    res   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_ready", byte_ready, 0);
    check("idle_no_write", wa_q.size(), 0);
    byte_valid = 1'b0;

    // Table-driven loads, full rate and gapped streams.
    for (int k = 0; k < 4; k++) begin
      do_load(k, vt[k].cnt, vt[k].nw, vt[k].gaps);
    end

    // Full-depth load: count 0 means 256 words.
    do_load(-1, 8'h00, 256, 1'b0);

    // Reset mid-load after the first word was written.
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    pulse_start();
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    @(negedge clk);
    res        = 1'b1;
    byte_in    = 8'h33;
    byte_valid = 1'b1;
    @(negedge clk);
    check("midrst_wr_en", mem_wr_en, 0);
    check("midrst_adr", mem_wr_adr, 0);
    check("midrst_data", mem_wr_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_hold", cpu_hold, 0);
    res = 1'b0;
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    check("midrst_writes", wa_q.size(), 1);
    if (wd_q.size() > 0) check("midrst_first_data", wd_q[0], 16'h1122);
    check("midrst_done", done_cnt, 0);
    do_load(0, vt[0].cnt, vt[0].nw, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: write stays, err sticky, CPU still held.
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hFE, 1'b0);
    repeat (4) @(negedge clk);
    check("chkbad_writes", wa_q.size(), 1);
    if (wd_q.size() > 0) check("chkbad_data", wd_q[0], 16'h55AA);
    check("chkbad_err", err, 1);
    check("chkbad_done", done_cnt, 0);
    check("chkbad_hold", cpu_hold, 1);
    // Good checksum clears err on start and completes.
    done_cnt = 0;
    pulse_start();
    check("chkgood_err_cleared", err, 0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hFF, 1'b0);
    repeat (4) @(negedge clk);
    check("chkgood_done", done_cnt, 1);
    check("chkgood_err", err, 0);
    check("chkgood_hold", cpu_hold, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
